// File: rtl/dot3_scheduler_pkg.sv
// Shared float-vector layout, FSM encoding and component helpers for the dot3 scheduler slice.
package dot3_scheduler_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned VEC3_W = 96;
  localparam int unsigned X_OFS  = 0;
  localparam int unsigned Y_OFS  = 32;
  localparam int unsigned Z_OFS  = 64;

  localparam logic [FP_W-1:0] FLOAT_ZERO = 32'h0;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeedX = 2'd1;
  localparam logic [1:0] StFeedY = 2'd2;
  localparam logic [1:0] StFeedZ = 2'd3;

  localparam logic [1:0] CompX = 2'd0;
  localparam logic [1:0] CompY = 2'd1;
  localparam logic [1:0] CompZ = 2'd2;

  function automatic logic [FP_W-1:0] vec3_comp(input logic [VEC3_W-1:0] v,
                                                 input logic [1:0]        sel);
    logic [FP_W-1:0] c;
    case (sel)
      CompX:   c = v[X_OFS +: FP_W];
      CompY:   c = v[Y_OFS +: FP_W];
      CompZ:   c = v[Z_OFS +: FP_W];
      default: c = FLOAT_ZERO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest-numbered request at or after ptr wins, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic            found;
  int unsigned     sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      cand = IdxW'(sum);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/dot3_scheduler.sv
// Shares one pipelined 3-D dot-product unit among N_REQ requesters: round-robin grant,
// x/y/z component streaming, in-flight tag tracking and back-pressure through the unit's clock enable.
module dot3_scheduler
  import dot3_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DOT_LAT = 19
) (
  input  logic                      clock,
  input  logic                      aclr_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*VEC3_W-1:0]   req_v1,
  input  logic [N_REQ*VEC3_W-1:0]   req_v2,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  output logic [N_REQ-1:0]          gnt,
  output logic                      dp_aclr,
  output logic                      dp_clk_en,
  output logic [FP_W-1:0]           dp_v1,
  output logic [FP_W-1:0]           dp_v2,
  input  logic [FP_W-1:0]           dp_result,
  output logic                      out_valid,
  output logic [$clog2(N_REQ)-1:0]  out_id,
  output logic [TAG_W-1:0]          out_tag,
  output logic [FP_W-1:0]           out_data,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned Last = DOT_LAT - 1;

  logic [1:0]       state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [FP_W-1:0]  lat_y1_q, lat_y1_d, lat_z1_q, lat_z1_d;
  logic [FP_W-1:0]  lat_y2_q, lat_y2_d, lat_z2_q, lat_z2_d;
  logic [IdW-1:0]   lat_id_q, lat_id_d;
  logic [TAG_W-1:0] lat_tag_q, lat_tag_d;
  logic [FP_W-1:0]  dp_v1_q, dp_v1_d, dp_v2_q, dp_v2_d;

  logic             out_valid_q;
  logic [IdW-1:0]   out_id_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [FP_W-1:0]  out_data_q;

  logic             stall, adv, can_grant, take;
  logic [N_REQ-1:0] arb_gnt;
  logic [IdW-1:0]   arb_idx;

  logic [VEC3_W-1:0] win_v1, win_v2;
  logic [TAG_W-1:0]  win_tag;

  logic [DOT_LAT-1:0] tp_valid;
  logic [IdW-1:0]     last_id;
  logic [TAG_W-1:0]   last_tag;

  // An un-accepted result freezes everything, including the external unit.
  assign stall     = out_valid_q & ~out_ready;
  assign adv       = ~stall;
  assign can_grant = adv & ((state_q == StIdle) | (state_q == StFeedZ));
  assign take      = can_grant & (|req);

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    win_v1  = '0;
    win_v2  = '0;
    win_tag = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_v1  = req_v1[i*VEC3_W +: VEC3_W];
        win_v2  = req_v2[i*VEC3_W +: VEC3_W];
        win_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lat_y1_d  = lat_y1_q;
    lat_z1_d  = lat_z1_q;
    lat_y2_d  = lat_y2_q;
    lat_z2_d  = lat_z2_q;
    lat_id_d  = lat_id_q;
    lat_tag_d = lat_tag_q;
    dp_v1_d   = dp_v1_q;
    dp_v2_d   = dp_v2_q;
    if (adv) begin
      case (state_q)
        StIdle, StFeedZ: begin
          if (take) begin
            // x goes straight to the port register so it is presented during FEED_X.
            state_d   = StFeedX;
            ptr_d     = (arb_idx == IdW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            dp_v1_d   = vec3_comp(win_v1, CompX);
            dp_v2_d   = vec3_comp(win_v2, CompX);
            lat_y1_d  = vec3_comp(win_v1, CompY);
            lat_z1_d  = vec3_comp(win_v1, CompZ);
            lat_y2_d  = vec3_comp(win_v2, CompY);
            lat_z2_d  = vec3_comp(win_v2, CompZ);
            lat_id_d  = arb_idx;
            lat_tag_d = win_tag;
          end else begin
            state_d = StIdle;
            dp_v1_d = FLOAT_ZERO;
            dp_v2_d = FLOAT_ZERO;
          end
        end
        StFeedX: begin
          state_d = StFeedY;
          dp_v1_d = lat_y1_q;
          dp_v2_d = lat_y2_q;
        end
        StFeedY: begin
          state_d = StFeedZ;
          dp_v1_d = lat_z1_q;
          dp_v2_d = lat_z2_q;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      lat_y1_q  <= FLOAT_ZERO;
      lat_z1_q  <= FLOAT_ZERO;
      lat_y2_q  <= FLOAT_ZERO;
      lat_z2_q  <= FLOAT_ZERO;
      lat_id_q  <= '0;
      lat_tag_q <= '0;
      dp_v1_q   <= FLOAT_ZERO;
      dp_v2_q   <= FLOAT_ZERO;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lat_y1_q  <= lat_y1_d;
      lat_z1_q  <= lat_z1_d;
      lat_y2_q  <= lat_y2_d;
      lat_z2_q  <= lat_z2_d;
      lat_id_q  <= lat_id_d;
      lat_tag_q <= lat_tag_d;
      dp_v1_q   <= dp_v1_d;
      dp_v2_q   <= dp_v2_d;
    end
  end

  // Tag pipe: stage k holds the job whose x component entered the unit k+1 enabled cycles ago.
  for (genvar k = 0; k < DOT_LAT; k++) begin : g_tag_pipe
    logic             in_valid;
    logic [IdW-1:0]   in_id;
    logic [TAG_W-1:0] in_tag;
    logic             valid_q;
    logic [IdW-1:0]   id_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_head
      assign in_valid = (state_q == StFeedX);
      assign in_id    = lat_id_q;
      assign in_tag   = lat_tag_q;
    end else begin : g_body
      assign in_valid = g_tag_pipe[k-1].valid_q;
      assign in_id    = g_tag_pipe[k-1].id_q;
      assign in_tag   = g_tag_pipe[k-1].tag_q;
    end

    always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
        valid_q <= 1'b0;
        id_q    <= '0;
        tag_q   <= '0;
      end else if (adv) begin
        valid_q <= in_valid;
        id_q    <= in_id;
        tag_q   <= in_tag;
      end
    end

    assign tp_valid[k] = valid_q;
  end

  assign last_id  = g_tag_pipe[Last].id_q;
  assign last_tag = g_tag_pipe[Last].tag_q;

  // When not stalled any held result is being accepted, so the slot takes whatever lands now.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_tag_q   <= '0;
      out_data_q  <= FLOAT_ZERO;
    end else if (adv) begin
      out_valid_q <= tp_valid[Last];
      if (tp_valid[Last]) begin
        out_id_q   <= last_id;
        out_tag_q  <= last_tag;
        out_data_q <= dp_result;
      end
    end
  end

  assign gnt       = can_grant ? arb_gnt : '0;
  assign dp_aclr   = ~aclr_n;
  assign dp_clk_en = adv;
  assign dp_v1     = dp_v1_q;
  assign dp_v2     = dp_v2_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle) | (|tp_valid) | out_valid_q;

endmodule
